instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
Parametrised, synchronous instruction memory for the MIPS fetch stage. It is loaded at run time through a streaming load port and serves byte-addressed fetches with a registered, one-cycle read latency. It flags misaligned or out-of-range addresses and supports fetch-stage stalls. It sits between the PC register and the IF/ID pipeline register.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 6, word-address width; depth = 2**ADDR_W words
PC_W, 32, byte-address width of fetch_addr; must satisfy PC_W >= ADDR_W+2
NOP_WORD, 32'h00000000, value driven on instr for faulted fetches and after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
load_valid  in  1  load word present
load_ready  out  1  block accepts a load word (state LOAD)
load_data  in  DATA_W  word to write
load_last  in  1  marks final load word
reload  in  1  single-cycle pulse: return to LOAD from RUN
fetch_req  in  1  fetch request
fetch_addr  in  PC_W  byte address (PC)
fetch_ready  out  1  fetch accepted this cycle when fetch_req=1
fetch_stall  in  1  downstream stall; hold the response
instr_valid  out  1  instr/instr_fault hold a valid response
instr  out  DATA_W  fetched instruction
instr_fault  out  1  last accepted fetch was misaligned or out of range
mem_ready  out  1  state RUN (program loaded)

Behaviour:
- States: LOAD, RUN. Asynchronous reset sets state=LOAD, load_ptr=0, instr_valid=0, instr=NOP_WORD, instr_fault=0. Memory array is not reset; contents survive reset.
- load_ready = (state==LOAD). fetch_ready = (state==RUN) && !fetch_stall. mem_ready = (state==RUN).
- LOAD:
  - Word accepted when load_valid && load_ready: mem[load_ptr] <= load_data, load_ptr <= load_ptr+1.
  - Transition to RUN on the accepting edge if load_last=1 or load_ptr==2**ADDR_W-1. load_ptr wraps to 0 and no extra write occurs.
  - Words beyond the accepted ones keep their prior contents.
  - fetch_req is ignored in LOAD. No response is produced.
- RUN:
  - A fetch is accepted when fetch_req && fetch_ready.
  - On the next edge: instr_valid=1. fault = (fetch_addr[1:0]!=0) || (fetch_addr[PC_W-1:ADDR_W+2]!=0).
  - If fault=1: instr=NOP_WORD, instr_fault=1.
  - If fault=0: instr=mem[fetch_addr[ADDR_W+1:2]], instr_fault=0.
  - Latency is exactly 1 cycle. Back-to-back accepted fetches give one response per cycle.
  - If fetch_req=0 and fetch_stall=0, instr_valid<=0 on the next edge. instr and instr_fault hold their last values.
  - If fetch_stall=1, instr_valid, instr and instr_fault all hold. No fetch is accepted.
- reload=1 in RUN: state<=LOAD, load_ptr<=0, instr_valid<=0. A fetch_req in the same cycle is not accepted. reload has priority over fetch and over fetch_stall. reload is ignored in LOAD.
- Reset mid-load: state returns to LOAD with load_ptr=0. Words already written stay in memory.
- Load writes and fetch reads never occur in the same cycle, because the states are exclusive.

Optional Feature:
IMEM_FETCH_CNT_EN
- Defined: adds output fetch_count [31:0].
  - Increments by 1 on each accepted fetch, faulted fetches included.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst and by reload.
  - Not cleared on the LOAD->RUN transition.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
1. Load words 32'h20080005, 32'h20090003, 32'h01095020 with load_last on the third. Then fetch 0x0, 0x4, 0x8 back-to-back -> instr_valid=1 for cycles 1-3 after the first request, with those three words in order, instr_fault=0, mem_ready=1.
2. After load, fetch_addr=0x6 and then 0x100 (ADDR_W=6) -> both responses have instr_fault=1 and instr=32'h00000000.
3. Stream 64 words (value = index) without load_last -> RUN entered on the 64th accept. Fetch 0xFC -> instr=32'h0000003F.
4. fetch_stall=1 for 3 cycles after a response instr=32'h20090003 -> instr/instr_valid held, fetch_ready=0, and no new fetch is accepted. Release the stall -> the next request is served.
5. Pulse reload while fetch_req=1 -> no response, load_ready=1 next cycle. Load 1 word 32'hDEADBEEF with load_last -> fetch 0x0 returns 32'hDEADBEEF, and fetch 0x4 returns the old word 32'h20090003.
6. Assert rst mid-load after 2 words -> all outputs return to reset values, and load_ptr restarts at 0. With IMEM_FETCH_CNT_EN, 5 fetches then reload -> fetch_count reads 5, then 0.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Purpose: run-time loadable instruction memory for the fetch stage; streams a program in, then serves PC fetches.
// Latency: one cycle from an accepted fetch to instr_valid; load words are written on the accepting edge.
// Backpressure: load_ready only in LOAD; fetch_ready drops on fetch_stall, which freezes the response registers.
// Optional: define IMEM_FETCH_CNT_EN to add the saturating fetch_count output.
module instr_mem_loadable #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 6,
   parameter int                PC_W     = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              reload,
   input  logic              fetch_req,
   input  logic [PC_W-1:0]   fetch_addr,
   output logic              fetch_ready,
   input  logic              fetch_stall,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic              instr_fault,
`ifdef IMEM_FETCH_CNT_EN
   output logic [31:0]       fetch_count,
`endif
   output logic              mem_ready
);

   typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] load_ptr;
   logic              load_accept;
   logic              fetch_accept;
   logic              fault;
   logic [ADDR_W-1:0] rd_idx;

   // Storage is deliberately not reset so a program survives rst.
   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   // Handshake qualifiers and fetch address decode.
   always_comb begin
      load_ready   = (state_q == LOAD);
      mem_ready    = (state_q == RUN);
      fetch_ready  = (state_q == RUN) && !fetch_stall;
      load_accept  = (state_q == LOAD) && load_valid;
      // reload wins over a fetch presented in the same cycle
      fetch_accept = fetch_req && fetch_ready && !reload;
      rd_idx       = fetch_addr[ADDR_W+1:2];
      // misaligned, or any byte-address bit above the array depth is set
      fault        = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (ADDR_W + 2)) != '0);
   end

   // Next-state logic: leave LOAD on the last word or when the array is full.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD: if (load_accept && (load_last || (load_ptr == '1))) state_d = RUN;
         RUN:  if (reload) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LOAD;
      else     state_q <= state_d;
   end

   // Load pointer: advances per accepted word (wrapping at full depth), restarts on reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             load_ptr <= '0;
      else if (load_accept)                load_ptr <= load_ptr + 1'b1;
      else if (state_q == RUN && reload)   load_ptr <= '0;
   end

   // Array write port, only active while loading.
   always_ff @(posedge clk) begin
      if (load_accept) mem[load_ptr] <= load_data;
   end

   // Response registers: capture on accept, drop valid when idle, freeze on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_valid <= 1'b0;
         instr       <= NOP_WORD;
         instr_fault <= 1'b0;
      end else if (state_q == RUN) begin
         if (reload) begin
            instr_valid <= 1'b0;
         end else if (!fetch_stall) begin
            instr_valid <= fetch_req;
            if (fetch_req) begin
               instr_fault <= fault;
               instr       <= fault ? NOP_WORD : mem[rd_idx];
            end
         end
      end
   end

`ifdef IMEM_FETCH_CNT_EN
   // Saturating count of accepted fetches; survives LOAD->RUN, cleared by reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   fetch_count <= '0;
      else if (state_q == RUN && reload)         fetch_count <= '0;
      else if (fetch_accept && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: load, fetch, faults, stall, reload, full load, reset mid-load.
module tb_instr_mem_loadable;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic        reload;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_fault;
   logic        mem_ready;
`ifdef IMEM_FETCH_CNT_EN
   logic [31:0] fetch_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   instr_mem_loadable dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
      .reload(reload),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready), .fetch_stall(fetch_stall),
      .instr_valid(instr_valid), .instr(instr), .instr_fault(instr_fault),
`ifdef IMEM_FETCH_CNT_EN
      .fetch_count(fetch_count),
`endif
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      load_valid = 1'b1; load_data = d; load_last = last;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      fetch_req = 1'b1; fetch_addr = a;
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load_valid = 0; load_data = 0; load_last = 0; reload = 0;
      fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", instr_valid); end
      n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 00000000", instr); end
      n_cmp++; if (instr_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %b want 0", instr_fault); end
      n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL rst_load_ready got %b want 1", load_ready); end
      n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready got %b want 0", mem_ready); end
      fetch_req = 1'b1;
      #1;
      n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_ready got %b want 0", fetch_ready); end
      tick();
      fetch_req = 1'b0;
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL load_fetch_ignored got %b want 0", instr_valid); end
   endtask

   task automatic test_load_fetch();
      logic [31:0] prog [3];
      prog[0] = 32'h20080005; prog[1] = 32'h20090003; prog[2] = 32'h01095020;
      load_word(prog[0], 1'b0);
      load_word(prog[1], 1'b0);
      n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_load_mem_ready got %b want 0", mem_ready); end
      load_word(prog[2], 1'b1);
      n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL post_load_mem_ready got %b want 1", mem_ready); end
      n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL post_load_load_ready got %b want 0", load_ready); end
      fetch_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_addr = 32'(i * 4);
         tick();
         n_cmp++; if (instr_valid !== 1'b1 || instr !== prog[i] || instr_fault !== 1'b0) begin
            n_fail++; $display("FAIL b2b_fetch%0d got v=%b i=%h f=%b want v=1 i=%h f=0", i, instr_valid, instr, instr_fault, prog[i]);
         end
      end
      fetch_req = 1'b0;
      tick();
      n_cmp++; if (instr_valid !== 1'b0 || instr !== prog[2]) begin
         n_fail++; $display("FAIL idle_drop got v=%b i=%h want v=0 i=%h", instr_valid, instr, prog[2]);
      end
   endtask

   task automatic test_fault();
      fetch(32'h6);
      n_cmp++; if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instr !== 32'h0) begin
         n_fail++; $display("FAIL misaligned got v=%b f=%b i=%h want v=1 f=1 i=00000000", instr_valid, instr_fault, instr);
      end
      fetch(32'h100);
      n_cmp++; if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instr !== 32'h0) begin
         n_fail++; $display("FAIL out_of_range got v=%b f=%b i=%h want v=1 f=1 i=00000000", instr_valid, instr_fault, instr);
      end
      fetch(32'h8000_0000);
      n_cmp++; if (instr_fault !== 1'b1 || instr !== 32'h0) begin
         n_fail++; $display("FAIL msb_range got f=%b i=%h want f=1 i=00000000", instr_fault, instr);
      end
      fetch(32'h8);
      n_cmp++; if (instr_fault !== 1'b0 || instr !== 32'h01095020) begin
         n_fail++; $display("FAIL fault_clear got f=%b i=%h want f=0 i=01095020", instr_fault, instr);
      end
   endtask

   task automatic test_stall();
      fetch_req = 1'b1; fetch_addr = 32'h4;
      tick();
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h20090003) begin
         n_fail++; $display("FAIL pre_stall got v=%b i=%h want v=1 i=20090003", instr_valid, instr);
      end
      fetch_stall = 1'b1; fetch_addr = 32'h8;
      #1;
      n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", fetch_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h20090003 || instr_fault !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold%0d got v=%b i=%h f=%b want v=1 i=20090003 f=0", i, instr_valid, instr, instr_fault);
         end
      end
      fetch_stall = 1'b0;
      #1;
      n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_ready got %b want 1", fetch_ready); end
      tick();
      fetch_req = 1'b0;
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h01095020) begin
         n_fail++; $display("FAIL post_stall got v=%b i=%h want v=1 i=01095020", instr_valid, instr);
      end
   endtask

   task automatic test_reload();
      fetch_req = 1'b1; fetch_addr = 32'h0; reload = 1'b1;
      tick();
      fetch_req = 1'b0; reload = 1'b0;
      n_cmp++; if (instr_valid !== 1'b0 || load_ready !== 1'b1 || mem_ready !== 1'b0) begin
         n_fail++; $display("FAIL reload got v=%b lr=%b mr=%b want v=0 lr=1 mr=0", instr_valid, load_ready, mem_ready);
      end
      n_cmp++; if (instr !== 32'h01095020) begin n_fail++; $display("FAIL reload_instr_hold got %h want 01095020", instr); end
      load_word(32'hDEADBEEF, 1'b1);
      fetch(32'h0);
      n_cmp++; if (instr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reload_word0 got %h want deadbeef", instr); end
      fetch(32'h4);
      n_cmp++; if (instr !== 32'h20090003) begin n_fail++; $display("FAIL reload_word1_kept got %h want 20090003", instr); end
   endtask

   task automatic test_full_load();
      pulse_reload();
      for (int i = 0; i < 64; i++) begin
         load_word(32'(i), 1'b0);
         if (i == 62) begin
            n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL full_63_mem_ready got %b want 0", mem_ready); end
         end
      end
      n_cmp++; if (mem_ready !== 1'b1 || load_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_64 got mr=%b lr=%b want mr=1 lr=0", mem_ready, load_ready);
      end
      fetch(32'hFC);
      n_cmp++; if (instr !== 32'h0000003F || instr_fault !== 1'b0) begin
         n_fail++; $display("FAIL full_last got i=%h f=%b want i=0000003f f=0", instr, instr_fault);
      end
      fetch(32'h10);
      n_cmp++; if (instr !== 32'h00000004) begin n_fail++; $display("FAIL full_mid got %h want 00000004", instr); end
   endtask

   task automatic test_reset_midload();
      pulse_reload();
      load_word(32'hAAAA0000, 1'b0);
      load_word(32'hAAAA0001, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (instr !== 32'h0 || instr_valid !== 1'b0 || instr_fault !== 1'b0 || load_ready !== 1'b1 || mem_ready !== 1'b0) begin
         n_fail++; $display("FAIL async_rst got i=%h v=%b f=%b lr=%b mr=%b want 0 0 0 1 0", instr, instr_valid, instr_fault, load_ready, mem_ready);
      end
      tick();
      rst = 1'b0;
      load_word(32'hBBBB0000, 1'b1);
      fetch(32'h0);
      n_cmp++; if (instr !== 32'hBBBB0000) begin n_fail++; $display("FAIL rst_ptr_restart got %h want bbbb0000", instr); end
      fetch(32'h4);
      n_cmp++; if (instr !== 32'hAAAA0001) begin n_fail++; $display("FAIL rst_mem_kept got %h want aaaa0001", instr); end
      fetch(32'h8);
      n_cmp++; if (instr !== 32'h00000002) begin n_fail++; $display("FAIL rst_old_word got %h want 00000002", instr); end
   endtask

`ifdef IMEM_FETCH_CNT_EN
   task automatic test_fetch_count();
      pulse_reload();
      n_cmp++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL cnt_reload0 got %0d want 0", fetch_count); end
      load_word(32'h11111111, 1'b1);
      fetch_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         fetch_addr = (i == 2) ? 32'h3 : 32'(i * 4);
         tick();
      end
      fetch_stall = 1'b1;
      tick();
      fetch_stall = 1'b0; fetch_req = 1'b0;
      n_cmp++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL cnt_five got %0d want 5", fetch_count); end
      pulse_reload();
      n_cmp++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL cnt_clear got %0d want 0", fetch_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_fetch();
      test_fault();
      test_stall();
      test_reload();
      test_full_load();
      test_reset_midload();
`ifdef IMEM_FETCH_CNT_EN
      test_fetch_count();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
